// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: reads opcodes from synchronous program memory,
// resolves JMP/RETI/HALT locally, issues the rest over valid/ready.
module instr_fetch_sequencer #(
   parameter int unsigned       ADDR_W     = 8,
   parameter logic [ADDR_W-1:0] IRQ_VECTOR = ADDR_W'(8'hF0)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              imem_rd_en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [7:0]        imem_rd_data,
   output logic [7:0]        instr,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              interrupt,
   output logic              irq_ack,
   output logic [ADDR_W-1:0] pc,
   output logic              in_isr,
   output logic              busy,
   output logic              halted
);

   localparam logic [7:0] OP_HALT = 8'hFF;
   localparam logic [7:0] OP_JMP  = 8'h40;
   localparam logic [7:0] OP_RETI = 8'h50;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_JFETCH, S_JWAIT, S_HALTED
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_pc, w_pc_nxt;
   logic [ADDR_W-1:0] r_epc, w_epc_nxt;
   logic [7:0]        r_ir, w_ir_nxt;
   logic              r_in_isr, w_in_isr_nxt;
   logic              r_irq_d, r_irq_pending;
   logic              w_irq_edge, w_take;

   assign w_irq_edge = interrupt & ~r_irq_d;

   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_epc_nxt    = r_epc;
      w_ir_nxt     = r_ir;
      w_in_isr_nxt = r_in_isr;
      w_take       = 1'b0;
      imem_rd_en   = 1'b0;
      imem_addr    = '0;
      instr        = '0;
      instr_valid  = 1'b0;
      unique case (r_state)
         S_IDLE: if (start) w_state_nxt = S_FETCH;
         S_FETCH: begin
            imem_rd_en  = 1'b1;
            imem_addr   = r_pc;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            w_ir_nxt    = imem_rd_data;
            w_pc_nxt    = r_pc + ADDR_W'(1);
            w_state_nxt = S_ISSUE;
            case (imem_rd_data)
               OP_HALT: w_state_nxt = S_HALTED;
               OP_JMP:  w_state_nxt = S_JFETCH;
               OP_RETI: begin
                  // RETI outside a handler is a silent NOP
                  w_state_nxt = S_FETCH;
                  if (r_in_isr) begin
                     w_pc_nxt     = r_epc;
                     w_in_isr_nxt = 1'b0;
                  end
               end
               default: ;
            endcase
         end
         S_ISSUE: begin
            instr_valid = 1'b1;
            instr       = r_ir;
            if (instr_ready) begin
               w_state_nxt = S_FETCH;
               w_take      = r_irq_pending & ~r_in_isr;
            end
         end
         S_JFETCH: begin
            imem_rd_en  = 1'b1;
            imem_addr   = r_pc;
            w_state_nxt = S_JWAIT;
         end
         S_JWAIT: begin
            w_pc_nxt    = ADDR_W'(imem_rd_data);
            w_state_nxt = S_FETCH;
         end
         S_HALTED: w_take = r_irq_pending & ~r_in_isr;
         default:  w_state_nxt = S_IDLE;
      endcase
      // pc already points past the issued instr / HALT, so it is the return address
      if (w_take) begin
         w_epc_nxt    = r_pc;
         w_pc_nxt     = IRQ_VECTOR;
         w_in_isr_nxt = 1'b1;
         w_state_nxt  = S_FETCH;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_pc          <= '0;
         r_epc         <= '0;
         r_ir          <= '0;
         r_in_isr      <= 1'b0;
         r_irq_d       <= 1'b0;
         r_irq_pending <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_pc     <= w_pc_nxt;
         r_epc    <= w_epc_nxt;
         r_ir     <= w_ir_nxt;
         r_in_isr <= w_in_isr_nxt;
         r_irq_d  <= interrupt;
         if (w_irq_edge)  r_irq_pending <= 1'b1;
         else if (w_take) r_irq_pending <= 1'b0;
      end
   end

   assign irq_ack = w_take;
   assign pc      = r_pc;
   assign in_isr  = r_in_isr;
   assign busy    = (r_state != S_IDLE) && (r_state != S_HALTED);
   assign halted  = (r_state == S_HALTED);

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Bench for instr_fetch_sequencer: directed scenarios plus random programs,
// checked against a timestamp-based instruction-level reference model.
module tb_instr_fetch_sequencer;

   localparam logic [7:0] VEC = 8'hF0;

   logic       clk = 1'b0;
   logic       reset = 1'b0, start = 1'b0, instr_ready = 1'b0, interrupt = 1'b0;
   logic       imem_rd_en, instr_valid, irq_ack, in_isr, busy, halted;
   logic [7:0] imem_addr, instr, pc;
   logic [7:0] imem_rd_data = '0;
   logic [7:0] mem [256];

   int checks = 0, errors = 0, cyc = 0;
   int n_xfer, n_ack, first_valid, start_cyc;

   // reference model: timestamps of upcoming events instead of a state machine
   int m_started, m_next_fetch, m_jfetch_at, m_issue_at, m_halt_at;
   int m_op, m_pc, m_epc, m_isr, m_pend, prev_irq;

   instr_fetch_sequencer #(.ADDR_W(8), .IRQ_VECTOR(VEC)) dut (
      .clk(clk), .reset(reset), .start(start),
      .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rd_data(imem_rd_data),
      .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .interrupt(interrupt), .irq_ack(irq_ack), .pc(pc),
      .in_isr(in_isr), .busy(busy), .halted(halted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (imem_rd_en) imem_rd_data <= mem[imem_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      m_started = 0; m_next_fetch = -1; m_jfetch_at = -1; m_issue_at = -1;
      m_halt_at = -1; m_op = 0; m_pc = 0; m_epc = 0; m_isr = 0; m_pend = 0;
      prev_irq = 0; n_xfer = 0; n_ack = 0; first_valid = -1; start_cyc = -1;
   endtask

   task automatic model_take();
      m_epc = m_pc; m_pc = VEC; m_isr = 1; m_pend = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); cyc++;
      #1 reset = 1'b1; start = 1'b0; instr_ready = 1'b0; interrupt = 1'b0;
      @(posedge clk); cyc++;
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_rd_en", imem_rd_en, 0);
      check("rst_addr", imem_addr, 0);
      check("rst_instr", instr, 0);
      check("rst_valid", instr_valid, 0);
      check("rst_ack", irq_ack, 0);
      check("rst_pc", pc, 0);
      check("rst_in_isr", in_isr, 0);
      check("rst_busy", busy, 0);
      check("rst_halted", halted, 0);
      model_reset();
   endtask

   task automatic cycle(input bit st, input bit rdy, input bit irq);
      bit e_rd, e_ack, e_halt, e_busy;
      int e_addr, op;
      @(posedge clk); cyc++;
      #1 start = st; instr_ready = rdy; interrupt = irq;
      @(negedge clk);
      e_rd = 0; e_ack = 0; e_halt = 0; e_addr = 0;
      e_busy = (m_started != 0) && !(m_halt_at >= 0 && cyc >= m_halt_at);
      if (m_started != 0 && cyc == m_next_fetch) begin
         e_rd = 1; e_addr = m_pc;
         op = mem[m_pc];
         m_pc = (m_pc + 1) % 256;
         if (op == 8'hFF) m_halt_at = cyc + 2;
         else if (op == 8'h40) begin m_jfetch_at = cyc + 2; m_next_fetch = cyc + 4; end
         else if (op == 8'h50) begin
            if (m_isr != 0) begin m_pc = m_epc; m_isr = 0; end
            m_next_fetch = cyc + 2;
         end else begin m_op = op; m_issue_at = cyc + 2; end
      end
      if (cyc == m_jfetch_at) begin
         e_rd = 1; e_addr = m_pc;
         m_pc = mem[m_pc];
         m_jfetch_at = -1;
      end
      if (m_issue_at >= 0 && cyc >= m_issue_at) begin
         check("valid", instr_valid, 1);
         check("instr", instr, m_op);
         check("pc_issue", pc, m_pc);
         check("in_isr", in_isr, m_isr);
         if (rdy) begin
            if (m_pend != 0 && m_isr == 0) begin e_ack = 1; model_take(); end
            m_issue_at = -1; m_next_fetch = cyc + 1;
         end
      end else check("valid", instr_valid, 0);
      if (m_halt_at >= 0 && cyc >= m_halt_at) begin
         e_halt = 1;
         check("pc_halt", pc, m_pc);
         if (m_pend != 0 && m_isr == 0) begin
            e_ack = 1; model_take();
            m_halt_at = -1; m_next_fetch = cyc + 1;
         end
      end
      check("rd_en", imem_rd_en, e_rd);
      if (e_rd) check("addr", imem_addr, e_addr);
      check("irq_ack", irq_ack, e_ack);
      check("halted", halted, e_halt);
      check("busy", busy, e_busy);
      if (irq && prev_irq == 0) m_pend = 1;
      prev_irq = irq;
      if (st && m_started == 0) begin m_started = 1; m_next_fetch = cyc + 1; start_cyc = cyc; end
      if (instr_valid && first_valid < 0) first_valid = cyc;
      if (instr_valid && rdy) n_xfer++;
      if (irq_ack) n_ack++;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
   endtask

   initial begin
      model_reset();
      clear_mem();

      // basic issue stream and halt
      mem[8'h00] = 8'h20; mem[8'h01] = 8'h30; mem[8'h02] = 8'hFF;
      do_reset();
      cycle(1, 1, 0);
      repeat (12) cycle(0, 1, 0);
      check("t1_latency", first_valid - start_cyc, 3);
      check("t1_xfers", n_xfer, 2);
      check("t1_halted", halted, 1);
      check("t1_pc", pc, 8'h03);

      // backpressure: five stalled cycles
      do_reset();
      cycle(1, 0, 0);
      repeat (7) cycle(0, 0, 0);
      check("t2_xfers_stalled", n_xfer, 0);
      repeat (10) cycle(0, 1, 0);
      check("t2_xfers", n_xfer, 2);

      // JMP resolved locally
      clear_mem();
      mem[8'h00] = 8'h40; mem[8'h01] = 8'h80; mem[8'h80] = 8'h20;
      do_reset();
      cycle(1, 1, 0);
      repeat (12) cycle(0, 1, 0);
      check("t3_latency", first_valid - start_cyc, 7);
      check("t3_xfers", n_xfer, 1);
      check("t3_pc", pc, 8'h82);

      // interrupt at issue boundary, RETI resumes
      clear_mem();
      mem[8'h00] = 8'h20; mem[8'h01] = 8'h30; mem[8'h02] = 8'hFF; mem[8'hF0] = 8'h50;
      do_reset();
      cycle(1, 1, 0);
      cycle(0, 1, 1);
      repeat (20) cycle(0, 1, 0);
      check("t4_acks", n_ack, 1);
      check("t4_xfers", n_xfer, 2);
      check("t4_pc", pc, 8'h03);
      check("t4_in_isr", in_isr, 0);

      // interrupt from HALTED, second edge held off until after RETI
      mem[8'hF0] = 8'h11; mem[8'hF1] = 8'h50; mem[8'h03] = 8'hFF; mem[8'h04] = 8'hFF;
      do_reset();
      cycle(1, 1, 0);
      repeat (12) cycle(0, 1, 0);
      cycle(0, 1, 1);
      cycle(0, 0, 0);
      cycle(0, 0, 1);
      cycle(0, 0, 0);
      repeat (30) cycle(0, 1, 0);
      check("t5_acks", n_ack, 2);
      check("t5_pc", pc, 8'h05);
      check("t5_halted", halted, 1);

      // pc wrap, then reset while issuing
      clear_mem();
      mem[8'h00] = 8'h40; mem[8'h01] = 8'hFF; mem[8'hFF] = 8'h20;
      do_reset();
      cycle(1, 0, 0);
      repeat (7) cycle(0, 0, 0);
      check("t6_valid", instr_valid, 1);
      check("t6_wrap_pc", pc, 8'h00);
      do_reset();
      repeat (3) cycle(0, 1, 0);

      // random programs, ready and interrupt pulses
      for (int run = 0; run < 6; run++) begin
         for (int a = 0; a < 256; a++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 99);
            b = 8'($urandom_range(0, 255));
            if (b == 8'hFF || b == 8'h40 || b == 8'h50) b = 8'h01;
            if (r < 4) b = 8'hFF;
            else if (r < 12) b = 8'h40;
            else if (r < 18) b = 8'h50;
            mem[a] = b;
         end
         mem[8'hF0] = 8'h11; mem[8'hF1] = 8'h50;
         do_reset();
         cycle(1, 1, 0);
         repeat (400) cycle(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
